irrigation_cycle_timer: RTL and testbench

//   Parametrised irrigation cycle timer with an N-digit BCD countdown for the 7-seg display.
//   Per-digit set/reset decoding is replaced by a clocked FSM that checks the tank level sensors
//   and the irrigation mode, loads a mode/level-dependent duration, and counts it down on tick.

---
 rtl/irrigation_pkg.sv | 34 +++
 rtl/bcd_digit_down.sv | 35 +++
 rtl/irrigation_cycle_timer.sv | 176 +++++++++++++++++
 tb/tb_irrigation_cycle_timer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/irrigation_pkg.sv
// Shared types for the irrigation cycle timer: FSM states, fault codes and the
// elaboration-time decimal-to-BCD helper used to build the load constants.
package irrigation_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4,
        FAULT = 3'd5
    } stateT;

    localparam logic [1:0] FAULT_NONE   = 2'd0;
    localparam logic [1:0] FAULT_SENSOR = 2'd1;
    localparam logic [1:0] FAULT_EMPTY  = 2'd2;
    localparam logic [1:0] FAULT_MODE   = 2'd3;

    localparam int MAX_DIGITS = 4;

    // Digits beyond ndig are left at zero; the caller truncates to its own width.
    function automatic logic [4*MAX_DIGITS-1:0] dec_to_bcd(input int value, input int ndig);
        logic [4*MAX_DIGITS-1:0] res;
        int v;
        res = '0;
        v   = value;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < ndig) res[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit. Clear beats load beats decrement; a decrement only
// happens when the lower digits borrow, and a zero digit wraps to 9.
module bcd_digit_down
    import irrigation_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] loadVal,
    input  logic       dec_en,
    input  logic       borrow_in,
    output logic [3:0] digit,
    output logic       borrow_out,
    output logic       is_zero
);

    logic [3:0] digitNext;

    always_comb begin
        digitNext = digit;
        if (clear)                     digitNext = 4'd0;
        else if (load)                 digitNext = loadVal;
        else if (dec_en && borrow_in)  digitNext = is_zero ? 4'd9 : digit - 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) digit <= 4'd0;
        else        digit <= digitNext;
    end

    assign is_zero    = (digit == 4'd0);
    assign borrow_out = borrow_in & is_zero;

endmodule

// File: rtl/irrigation_cycle_timer.sv
// Irrigation cycle FSM with an N-digit BCD countdown driving the valve and display.
// Optional build macro LEADING_ZERO_BLANK_EN enables leading-zero blanking of the display.
module irrigation_cycle_timer
    import irrigation_pkg::*;
#(
    parameter int NUM_DIGITS    = 2,
    parameter int DUR_SPRINKLER = 15,
    parameter int DUR_DRIP      = 30
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tick,
    input  logic                    level_h,
    input  logic                    level_m,
    input  logic                    level_l,
    input  logic                    mode_spr,
    input  logic                    mode_drip,
    input  logic                    start,
    input  logic                    abort,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    valve_open,
    output logic                    done,
    output logic [1:0]              fault,
    output logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [2:0]              stateDbg
);

    localparam int W = 4 * NUM_DIGITS;
    localparam int SPR_HALF_TICKS  = (DUR_SPRINKLER / 2 > 0) ? DUR_SPRINKLER / 2 : 1;
    localparam int DRIP_HALF_TICKS = (DUR_DRIP / 2 > 0) ? DUR_DRIP / 2 : 1;
    localparam logic [W-1:0] SPR_FULL  = W'(dec_to_bcd(DUR_SPRINKLER, NUM_DIGITS));
    localparam logic [W-1:0] SPR_HALF  = W'(dec_to_bcd(SPR_HALF_TICKS, NUM_DIGITS));
    localparam logic [W-1:0] DRIP_FULL = W'(dec_to_bcd(DUR_DRIP, NUM_DIGITS));
    localparam logic [W-1:0] DRIP_HALF = W'(dec_to_bcd(DRIP_HALF_TICKS, NUM_DIGITS));

    stateT      stateQ, stateNext;
    logic [1:0] faultQ, faultNext;
    logic       modeDripQ;
    logic       armedQ;
    logic       sensorBad, tankEmpty, lowOnly;
    logic       loadEn, clearEn, decEn, lastTick, allZero;
    logic [W-1:0] loadVal;
    logic [NUM_DIGITS-1:0] borrowIn, borrowOut, isZero;

    assign sensorBad = (level_h & ~level_m) | (level_m & ~level_l);
    assign tankEmpty = ~level_l;
    assign lowOnly   = level_l & ~level_m;

    // Abort wins over every sensor and tick condition in the same cycle.
    assign clearEn = abort && ((stateQ inside {LOAD, RUN, PAUSE, DONE}) || (stateQ == FAULT && !start));
    assign loadEn  = (stateQ == LOAD) && !abort && !sensorBad && !tankEmpty;
    assign decEn   = (stateQ == RUN) && tick && !abort && !sensorBad && !tankEmpty && !allZero;
    assign allZero  = borrowOut[NUM_DIGITS-1];
    assign lastTick = (digits[3:0] == 4'd1) && (&(isZero | NUM_DIGITS'(1)));

    always_comb begin
        if (modeDripQ) loadVal = lowOnly ? DRIP_HALF : DRIP_FULL;
        else           loadVal = lowOnly ? SPR_HALF : SPR_FULL;
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : gDigit
        if (g == 0) begin : gLsd
            assign borrowIn[g] = 1'b1;
        end else begin : gUpper
            assign borrowIn[g] = borrowOut[g-1];
        end
        bcd_digit_down uDigit (
            .clk        (clk),
            .rst_n      (rst_n),
            .clear      (clearEn),
            .load       (loadEn),
            .loadVal    (loadVal[4*g +: 4]),
            .dec_en     (decEn),
            .borrow_in  (borrowIn[g]),
            .digit      (digits[4*g +: 4]),
            .borrow_out (borrowOut[g]),
            .is_zero    (isZero[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ    <= IDLE;
            faultQ    <= FAULT_NONE;
            modeDripQ <= 1'b0;
            armedQ    <= 1'b1;
        end else begin
            stateQ <= stateNext;
            faultQ <= faultNext;
            if (stateQ == IDLE && stateNext == LOAD) modeDripQ <= mode_drip;
            // After an abort a still-held start must drop once before it counts again.
            if (abort && (stateQ inside {LOAD, RUN, PAUSE, DONE})) armedQ <= 1'b0;
            else if (!start)                                       armedQ <= 1'b1;
        end
    end

    always_comb begin
        stateNext = stateQ;
        faultNext = faultQ;
        unique case (stateQ)
            IDLE: begin
                if (start && armedQ) begin
                    if (mode_spr && mode_drip) begin
                        stateNext = FAULT;
                        faultNext = FAULT_MODE;
                    end else if (mode_spr || mode_drip) begin
                        stateNext = LOAD;
                    end
                end
            end
            LOAD: begin
                if (abort)          stateNext = IDLE;
                else if (sensorBad) begin stateNext = FAULT; faultNext = FAULT_SENSOR; end
                else if (tankEmpty) begin stateNext = FAULT; faultNext = FAULT_EMPTY; end
                else                stateNext = RUN;
            end
            RUN: begin
                if (abort)                   stateNext = IDLE;
                else if (sensorBad)          begin stateNext = FAULT; faultNext = FAULT_SENSOR; end
                else if (tankEmpty)          stateNext = PAUSE;
                else if (decEn && lastTick)  stateNext = DONE;
            end
            PAUSE: begin
                if (abort)                        stateNext = IDLE;
                else if (level_l && !sensorBad)   stateNext = RUN;
            end
            DONE: begin
                if (abort || !start) stateNext = IDLE;
            end
            FAULT: begin
                if (abort && !start) begin
                    stateNext = IDLE;
                    faultNext = FAULT_NONE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        valve_open = (stateQ == RUN);
        done       = (stateQ == DONE);
        fault      = faultQ;
        stateDbg   = stateQ;
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] zeroAfter, maskNext;
    logic                  upperZero;

    // Predict which digits will be zero after this edge so the mask lands with the digits.
    always_comb begin
        zeroAfter = '0;
        maskNext  = '0;
        upperZero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (clearEn)                      zeroAfter[i] = 1'b1;
            else if (loadEn)                  zeroAfter[i] = (loadVal[4*i +: 4] == 4'd0);
            else if (decEn && borrowIn[i])    zeroAfter[i] = (digits[4*i +: 4] == 4'd1);
            else                              zeroAfter[i] = isZero[i];
        end
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            upperZero   = upperZero & zeroAfter[i];
            maskNext[i] = upperZero;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) blank_mask <= '0;
        else        blank_mask <= maskNext;
    end
`else
    assign blank_mask = '0;
`endif

endmodule

// File: tb/tb_irrigation_cycle_timer.sv
// Directed bench for irrigation_cycle_timer: a 2-digit default instance and a
// 3-digit instance (DUR_DRIP=100) checked through one expected-value queue.
`timescale 1ns/1ps
module tb_irrigation_cycle_timer;
    import irrigation_pkg::*;

    localparam int W = 22;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic levelH, levelM, levelL, modeSpr, modeDrip;
    logic start, abort, tick;
    logic start3, abort3, tick3;

    logic [7:0]  digits1;
    logic        valve1, done1;
    logic [1:0]  fault1, mask1;
    logic [2:0]  st1;
    logic [11:0] digits3;
    logic        valve3, done3;
    logic [1:0]  fault3;
    logic [2:0]  mask3, st3;

    logic [W-1:0] exp_q[$];
    int nCompared   = 0;
    int nMismatched = 0;

    always #5 clk = ~clk;

    irrigation_cycle_timer uDut (
        .clk(clk), .rst_n(rst_n), .tick(tick),
        .level_h(levelH), .level_m(levelM), .level_l(levelL),
        .mode_spr(modeSpr), .mode_drip(modeDrip), .start(start), .abort(abort),
        .digits(digits1), .valve_open(valve1), .done(done1), .fault(fault1),
        .blank_mask(mask1), .stateDbg(st1)
    );

    irrigation_cycle_timer #(.NUM_DIGITS(3), .DUR_DRIP(100)) uDut3 (
        .clk(clk), .rst_n(rst_n), .tick(tick3),
        .level_h(levelH), .level_m(levelM), .level_l(levelL),
        .mode_spr(modeSpr), .mode_drip(modeDrip), .start(start3), .abort(abort3),
        .digits(digits3), .valve_open(valve3), .done(done3), .fault(fault3),
        .blank_mask(mask3), .stateDbg(st3)
    );

    logic [W-1:0] obs1, obs3;
    assign obs1 = {st1, valve1, done1, fault1, 1'b0, mask1, 4'b0000, digits1};
    assign obs3 = {st3, valve3, done3, fault3, mask3, digits3};

    function automatic logic [7:0] bcd2(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    function automatic logic [11:0] bcd3(input int n);
        return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    function automatic logic [1:0] maskOf2(input int n);
        return (BLANK_ON && n < 10) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [2:0] maskOf3(input int n);
        if (!BLANK_ON) return 3'b000;
        if (n < 10)    return 3'b110;
        if (n < 100)   return 3'b100;
        return 3'b000;
    endfunction

    task automatic push1(input logic [2:0] st, input logic v, input logic d,
                         input logic [1:0] f, input int n, input bit inReset);
        exp_q.push_back({st, v, d, f, 1'b0, inReset ? 2'b00 : maskOf2(n), 4'b0000, bcd2(n)});
    endtask

    task automatic push3(input logic [2:0] st, input logic v, input logic d,
                         input logic [1:0] f, input int n, input bit inReset);
        exp_q.push_back({st, v, d, f, inReset ? 3'b000 : maskOf3(n), bcd3(n)});
    endtask

    task automatic compare(input string tag, input bit sel3);
        logic [W-1:0] e, o;
        o = sel3 ? obs3 : obs1;
        nCompared++;
        if (exp_q.size() == 0) begin
            nMismatched++;
            $display("FAIL %s: observed %h but no expected value queued", tag, o);
        end else begin
            e = exp_q.pop_front();
            assert (o === e) else begin
                nMismatched++;
                $error("FAIL %s: observed %h expected %h", tag, o, e);
            end
        end
    endtask

    task automatic step1(input string tag, input logic [2:0] st, input logic v,
                         input logic d, input logic [1:0] f, input int n);
        push1(st, v, d, f, n, 1'b0);
        @(posedge clk);
        #1;
        compare(tag, 1'b0);
    endtask

    task automatic step3(input string tag, input logic [2:0] st, input logic v,
                         input logic d, input logic [1:0] f, input int n);
        push3(st, v, d, f, n, 1'b0);
        @(posedge clk);
        #1;
        compare(tag, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        {levelH, levelM, levelL, modeSpr, modeDrip} = '0;
        {start, abort, tick, start3, abort3, tick3} = '0;
        #1;
        push1(IDLE, 0, 0, FAULT_NONE, 0, 1'b1);
        compare("reset_dut", 1'b0);
        push3(IDLE, 0, 0, FAULT_NONE, 0, 1'b1);
        compare("reset_dut3", 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Sprinkler, full tank: 15 ticks to done; start held keeps DONE.
        {levelH, levelM, levelL} = 3'b111;
        modeSpr = 1'b1; modeDrip = 1'b0; start = 1'b1;
        step1("spr_load", LOAD, 0, 0, FAULT_NONE, 0);
        step1("spr_run", RUN, 1, 0, FAULT_NONE, 15);
        for (int k = 1; k <= 15; k++) begin
            tick = 1'b1;
            if (k < 15) step1("spr_tick", RUN, 1, 0, FAULT_NONE, 15 - k);
            else        step1("spr_done", DONE, 0, 1, FAULT_NONE, 0);
            tick = 1'b0;
            if (k < 15) step1("spr_gap", RUN, 1, 0, FAULT_NONE, 15 - k);
            else        step1("spr_done_hold", DONE, 0, 1, FAULT_NONE, 0);
        end
        start = 1'b0;
        step1("spr_idle", IDLE, 0, 0, FAULT_NONE, 0);

        // Drip, low sensor only: half duration, pause on empty, abort with tick.
        {levelH, levelM, levelL} = 3'b001;
        modeSpr = 1'b0; modeDrip = 1'b1; start = 1'b1;
        step1("drip_load", LOAD, 0, 0, FAULT_NONE, 0);
        step1("drip_run", RUN, 1, 0, FAULT_NONE, 15);
        start = 1'b0;
        tick = 1'b1;
        for (int k = 1; k <= 8; k++) step1("drip_tick", RUN, 1, 0, FAULT_NONE, 15 - k);
        tick = 1'b0;
        levelL = 1'b0;
        step1("pause_enter", PAUSE, 0, 0, FAULT_NONE, 7);
        tick = 1'b1;
        repeat (3) step1("pause_tick", PAUSE, 0, 0, FAULT_NONE, 7);
        tick = 1'b0;
        levelL = 1'b1;
        step1("pause_resume", RUN, 1, 0, FAULT_NONE, 7);
        tick = 1'b1;
        step1("resume_tick", RUN, 1, 0, FAULT_NONE, 6);
        step1("resume_tick", RUN, 1, 0, FAULT_NONE, 5);
        abort = 1'b1; start = 1'b1;
        step1("abort_tick", IDLE, 0, 0, FAULT_NONE, 0);
        abort = 1'b0; tick = 1'b0;
        step1("start_held", IDLE, 0, 0, FAULT_NONE, 0);
        start = 1'b0;
        step1("start_low", IDLE, 0, 0, FAULT_NONE, 0);
        start = 1'b1;
        step1("rearm_load", LOAD, 0, 0, FAULT_NONE, 0);
        step1("rearm_run", RUN, 1, 0, FAULT_NONE, 15);
        start = 1'b0;
        tick = 1'b1;
        for (int k = 1; k <= 12; k++) step1("drip12_tick", RUN, 1, 0, FAULT_NONE, 15 - k);
        tick = 1'b0;

        // Asynchronous reset mid-cycle.
        #2;
        rst_n = 1'b0;
        #1;
        push1(IDLE, 0, 0, FAULT_NONE, 0, 1'b1);
        compare("reset_mid", 1'b0);
        @(negedge clk) rst_n = 1'b1;

        // Sensor inconsistency at load, held through abort while start is high.
        {levelH, levelM, levelL} = 3'b101;
        modeSpr = 1'b1; modeDrip = 1'b0; start = 1'b1;
        step1("f1_load", LOAD, 0, 0, FAULT_NONE, 0);
        step1("f1_fault", FAULT, 0, 0, FAULT_SENSOR, 0);
        abort = 1'b1;
        step1("f1_hold", FAULT, 0, 0, FAULT_SENSOR, 0);
        start = 1'b0;
        step1("f1_clear", IDLE, 0, 0, FAULT_NONE, 0);
        abort = 1'b0;

        // Empty tank at load.
        {levelH, levelM, levelL} = 3'b000;
        start = 1'b1;
        step1("f2_load", LOAD, 0, 0, FAULT_NONE, 0);
        step1("f2_fault", FAULT, 0, 0, FAULT_EMPTY, 0);
        start = 1'b0; abort = 1'b1;
        step1("f2_clear", IDLE, 0, 0, FAULT_NONE, 0);
        abort = 1'b0;

        // Mode conflict goes straight to FAULT; no mode is ignored.
        {levelH, levelM, levelL} = 3'b111;
        modeSpr = 1'b1; modeDrip = 1'b1; start = 1'b1;
        step1("f3_fault", FAULT, 0, 0, FAULT_MODE, 0);
        start = 1'b0; abort = 1'b1;
        step1("f3_clear", IDLE, 0, 0, FAULT_NONE, 0);
        abort = 1'b0;
        modeSpr = 1'b0; modeDrip = 1'b0; start = 1'b1;
        step1("no_mode", IDLE, 0, 0, FAULT_NONE, 0);
        step1("no_mode_hold", IDLE, 0, 0, FAULT_NONE, 0);
        start = 1'b0;
        step1("no_mode_low", IDLE, 0, 0, FAULT_NONE, 0);

        // Sensors become inconsistent while running: digits held in FAULT.
        modeSpr = 1'b1; start = 1'b1;
        step1("rf_load", LOAD, 0, 0, FAULT_NONE, 0);
        step1("rf_run", RUN, 1, 0, FAULT_NONE, 15);
        tick = 1'b1;
        step1("rf_tick", RUN, 1, 0, FAULT_NONE, 14);
        tick = 1'b0;
        levelM = 1'b0;
        step1("rf_fault", FAULT, 0, 0, FAULT_SENSOR, 14);
        start = 1'b0; abort = 1'b1;
        step1("rf_clear", IDLE, 0, 0, FAULT_NONE, 0);
        abort = 1'b0; levelM = 1'b1; modeSpr = 1'b0;

        // Three-digit instance: 100 -> 099 borrow across two digits, down to 009.
        modeDrip = 1'b1; start3 = 1'b1;
        step3("d3_load", LOAD, 0, 0, FAULT_NONE, 0);
        step3("d3_run", RUN, 1, 0, FAULT_NONE, 100);
        start3 = 1'b0;
        tick3 = 1'b1;
        step3("d3_borrow", RUN, 1, 0, FAULT_NONE, 99);
        for (int n = 98; n >= 10; n--) push3(RUN, 1, 0, FAULT_NONE, n, 1'b0);
        for (int n = 98; n >= 10; n--) begin
            @(posedge clk);
            #1;
            compare("d3_tick", 1'b1);
        end
        step3("d3_nine", RUN, 1, 0, FAULT_NONE, 9);
        tick3 = 1'b0;
        abort3 = 1'b1;
        step3("d3_abort", IDLE, 0, 0, FAULT_NONE, 0);
        abort3 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
